// File: rtl/branch_fetch_ctrl.sv
// branch_fetch_ctrl: fetch-stage PC register and IF/ID pipeline register for
// a classic 5-stage pipeline. It applies the hazard-unit stall and the
// redirect requests (jr, jump, taken branch) that the ID stage resolves.
//
// Ports
//   clk          : single clock, all state updates on the rising edge
//   reset        : synchronous, active-high reset
//   stall        : holds the PC and IF/ID; any redirect that cycle is ignored
//   br_true      : taken-branch decision from the ID comparator
//   br_target    : branch target computed in ID
//   jump         : j/jal redirect request; jump_target is its target
//   jr           : register-indirect redirect request; jr_target is its target
//   instr_f      : instruction read from IM at pc_f
//   pc_f         : current fetch PC driven to IM (always word aligned)
//   ir_d         : IF/ID instruction
//   pc_d         : IF/ID instruction PC
//   pc8_d        : IF/ID PC+8 (link value)
//   valid_d      : IF/ID holds a real instruction rather than a bubble
//
// Configuration
//   BRANCH_DELAY_SLOT_EN : when defined, the instruction fetched on a redirect
//                          edge (the delay slot) enters IF/ID as a valid
//                          instruction. When undefined, it is squashed into
//                          a nop bubble.

module branch_fetch_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_true,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] ir_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d
);

  localparam int unsigned XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_3000);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] LINK_OFS = XLEN'(8);

  logic            redirect_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] pc_next_c;
  logic [XLEN-1:0] ir_next_c;
  logic            valid_next_c;

  // Redirect detection and target select: jr > jump > branch, word aligned.
  always_comb begin
    redirect_c = jr | jump | br_true;
    target_c   = br_target;
    if (jr) begin
      target_c = jr_target;
    end else if (jump) begin
      target_c = jump_target;
    end
    target_c = {target_c[XLEN-1:2], 2'b00};
  end

  // Next PC and the IF/ID payload for a non-stalled edge.
  always_comb begin
    pc_next_c    = pc_f + PC_STEP;
    ir_next_c    = instr_f;
    valid_next_c = 1'b1;
    if (redirect_c) begin
      pc_next_c = target_c;
`ifdef BRANCH_DELAY_SLOT_EN
      ir_next_c    = instr_f;
      valid_next_c = 1'b1;
`else
      // Fall-through instruction is squashed into a bubble.
      ir_next_c    = '0;
      valid_next_c = 1'b0;
`endif
    end
  end

  // PC and IF/ID registers: reset > stall > redirect/sequential.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f    <= RESET_PC;
      ir_d    <= '0;
      pc_d    <= RESET_PC;
      pc8_d   <= RESET_PC + LINK_OFS;
      valid_d <= 1'b0;
    end else if (!stall) begin
      pc_f    <= pc_next_c;
      ir_d    <= ir_next_c;
      pc_d    <= pc_f;
      pc8_d   <= pc_f + LINK_OFS;
      valid_d <= valid_next_c;
    end
  end

endmodule

// File: tb/tb_branch_fetch_ctrl.sv
// Self-checking bench for branch_fetch_ctrl: directed scenarios with literal
// expectations, followed by randomized stall/redirect/reset traffic checked
// every cycle against a behavioural model of the fetch stage.

module tb_branch_fetch_ctrl;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_true;
  logic [31:0] br_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] ir_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        valid_d;

  int checks = 0;
  int errors = 0;

  branch_fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br_true     (br_true),
    .br_target   (br_target),
    .jump        (jump),
    .jump_target (jump_target),
    .jr          (jr),
    .jr_target   (jr_target),
    .instr_f     (instr_f),
    .pc_f        (pc_f),
    .ir_d        (ir_d),
    .pc_d        (pc_d),
    .pc8_d       (pc8_d),
    .valid_d     (valid_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  assign instr_f = imem(pc_f);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the fetch stage as a PC plus the last fetched slot.
  logic [31:0] m_pc, m_ir, m_pcd, m_pc8;
  logic        m_valid;
  logic        m_known = 1'b0;

  always @(posedge clk) begin
    logic [31:0] tgt;
    if (reset) begin
      m_pc    <= 32'h3000;
      m_ir    <= 32'h0;
      m_pcd   <= 32'h3000;
      m_pc8   <= 32'h3008;
      m_valid <= 1'b0;
      m_known <= 1'b1;
    end else if (m_known && !stall) begin
      // The instruction that was at the fetch PC moves into ID in any case.
      m_pcd <= m_pc;
      m_pc8 <= m_pc + 32'd8;
      if (jr || jump || br_true) begin
        tgt = jr ? jr_target : (jump ? jump_target : br_target);
        m_pc    <= tgt & ~32'd3;
        m_ir    <= DS ? imem(m_pc) : 32'h0;
        m_valid <= DS;
      end else begin
        m_pc    <= m_pc + 32'd4;
        m_ir    <= imem(m_pc);
        m_valid <= 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_known) begin
      chk("pc_f", pc_f, m_pc);
      chk("ir_d", ir_d, m_ir);
      chk("pc_d", pc_d, m_pcd);
      chk("pc8_d", pc8_d, m_pc8);
      chk("valid_d", 32'(valid_d), 32'(m_valid));
    end
  end

  task automatic idle();
    reset = 1'b0; stall = 1'b0;
    br_true = 1'b0; jump = 1'b0; jr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] h_pc, h_ir, h_pcd, h_pc8;
  logic        h_v;

  initial begin
    idle();
    br_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0;

    // Reset for two cycles.
    reset = 1'b1;
    tick(); tick();
    chk("rst_pc_f", pc_f, 32'h3000);
    chk("rst_ir_d", ir_d, 32'h0);
    chk("rst_pc_d", pc_d, 32'h3000);
    chk("rst_pc8_d", pc8_d, 32'h3008);
    chk("rst_valid", 32'(valid_d), 32'd0);

    // Sequential fetch.
    idle();
    tick();
    chk("seq1_pc_f", pc_f, 32'h3004);
    chk("seq1_ir_d", ir_d, imem(32'h3000));
    chk("seq1_pc8_d", pc8_d, 32'h3008);
    chk("seq1_valid", 32'(valid_d), 32'd1);
    tick();
    chk("seq2_pc_f", pc_f, 32'h3008);
    chk("seq2_pc_d", pc_d, 32'h3004);
    chk("seq2_pc8_d", pc8_d, 32'h300C);

    // Taken branch at 0x3008.
    br_true = 1'b1; br_target = 32'h3020;
    tick();
    chk("br_pc_f", pc_f, 32'h3020);
    chk("br_ir_d", ir_d, DS ? imem(32'h3008) : 32'h0);
    chk("br_valid", 32'(valid_d), DS ? 32'd1 : 32'd0);
    chk("br_pc_d", pc_d, 32'h3008);
    idle();
    tick();
    chk("br_tgt_ir_d", ir_d, imem(32'h3020));
    chk("br_tgt_pc_d", pc_d, 32'h3020);

    // Stall masks a jump.
    h_pc = pc_f; h_ir = ir_d; h_pcd = pc_d; h_pc8 = pc8_d; h_v = valid_d;
    stall = 1'b1; jump = 1'b1; jump_target = 32'h3100;
    tick();
    chk("stall_pc_f", pc_f, 32'h3024);
    chk("stall_ir_d", ir_d, h_ir);
    chk("stall_pc_d", pc_d, h_pcd);
    chk("stall_pc8_d", pc8_d, h_pc8);
    chk("stall_valid", 32'(valid_d), 32'(h_v));
    chk("stall_pc_hold", pc_f, h_pc);
    stall = 1'b0;
    tick();
    chk("jump_pc_f", pc_f, 32'h3100);

    // Priority and alignment: jr wins over branch, low bits cleared.
    idle();
    jr = 1'b1; jr_target = 32'h3043; br_true = 1'b1; br_target = 32'h3200;
    tick();
    chk("jr_pc_f", pc_f, 32'h3040);

    // Reset coincident with a taken branch.
    idle();
    reset = 1'b1; br_true = 1'b1; br_target = 32'h3400;
    tick();
    chk("rbr_pc_f", pc_f, 32'h3000);
    chk("rbr_valid", 32'(valid_d), 32'd0);
    chk("rbr_ir_d", ir_d, 32'h0);
    idle();
    tick();
    chk("rbr_first_pc_d", pc_d, 32'h3000);
    chk("rbr_first_ir_d", ir_d, imem(32'h3000));

    // Wrap-around.
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick();
    chk("wrap_pc_f0", pc_f, 32'hFFFF_FFFC);
    idle();
    tick();
    chk("wrap_pc_f1", pc_f, 32'h0000_0000);
    chk("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
    chk("wrap_pc8_d", pc8_d, 32'h0000_0004);

    // Randomized traffic checked by the per-cycle comparison.
    for (int i = 0; i < 2000; i++) begin
      reset       = ($urandom_range(0, 99) < 2);
      stall       = ($urandom_range(0, 99) < 25);
      br_true     = ($urandom_range(0, 99) < 15);
      jump        = ($urandom_range(0, 99) < 10);
      jr          = ($urandom_range(0, 99) < 10);
      br_target   = $urandom;
      jump_target = $urandom;
      jr_target   = $urandom;
      if ($urandom_range(0, 3) == 0) jump_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      tick();
    end
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_fetch_ctrl.md
BRANCH_FETCH_CTRL -- requirements
Module: branch_fetch_ctrl

Interface
REQ-001 The block SHALL use `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL use `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have `stall`, input, 1 bit: hazard-unit hold of the PC and the IF/ID register.
REQ-004 The block SHALL have `br_true`, input, 1 bit: branch-taken decision from the ID-stage comparator.
REQ-005 The block SHALL have `br_target`, input, 32 bits: branch target computed in ID.
REQ-006 The block SHALL have `jump`, input, 1 bit, with `jump_target`, input, 32 bits: j/jal redirect.
REQ-007 The block SHALL have `jr`, input, 1 bit, with `jr_target`, input, 32 bits: register-indirect redirect.
REQ-008 The block SHALL have `instr_f`, input, 32 bits: instruction read from IM at `pc_f`.
REQ-009 The block SHALL have `pc_f`, output, 32 bits: current fetch PC driven to IM.
REQ-010 The block SHALL have `ir_d`, `pc_d` and `pc8_d`, outputs, 32 bits each: IF/ID instruction, its PC, and its PC+8 (link value).
REQ-011 The block SHALL have `valid_d`, output, 1 bit: the IF/ID register holds a real instruction rather than a bubble.

Function
REQ-012 Redirect SHALL be `jr | jump | br_true`; the target SHALL be selected with priority `jr_target` > `jump_target` > `br_target`.
REQ-013 Low two bits of any selected target SHALL be forced to 00; `pc_f[1:0]` SHALL always be 00.
REQ-014 Per edge, priority SHALL be `reset` > `stall` > redirect > sequential.
REQ-015 With `stall`=1, `pc_f`, `ir_d`, `pc_d`, `pc8_d` and `valid_d` SHALL hold, and any redirect input that cycle SHALL be ignored. The held ID instruction re-presents the decision next cycle.
REQ-016 With no stall and no redirect:
- `pc_f` SHALL become `pc_f`+4.
- IF/ID SHALL load {`instr_f`, `pc_f`, `pc_f`+8}.
- `valid_d` SHALL be set to 1.
REQ-017 With no stall and redirect, `pc_f` SHALL become the selected target; IF/ID SHALL be loaded as stated in REQ-025/026.
REQ-018 Latency: a redirect asserted in cycle N SHALL make `pc_f` equal the target in cycle N+1, and the target instruction SHALL appear in `ir_d` in cycle N+2.
REQ-019 PC arithmetic SHALL be modulo 2^32: `pc_f`=0xFFFFFFFC SHALL wrap to 0x00000000 without a flag.
REQ-020 Redirect inputs SHALL be sampled only; they SHALL NOT be registered beyond the PC update.
REQ-021 All outputs SHALL be register outputs; there SHALL be no combinational path from any input to any output.

Reset
REQ-022 On a `reset`=1 edge, `pc_f` SHALL become 0x00003000.
REQ-023 On a `reset`=1 edge, `ir_d`=0x00000000, `pc_d`=0x00003000, `pc8_d`=0x00003008 and `valid_d`=0.
REQ-024 Reset SHALL override a simultaneous `stall` or redirect. A redirect pending when reset asserts SHALL be discarded, and fetch SHALL restart at 0x00003000 on the first edge after `reset` falls.

Configuration
REQ-025 With macro `BRANCH_DELAY_SLOT_EN` defined, a redirect edge SHALL still load IF/ID with {`instr_f`, `pc_f`, `pc_f`+8, `valid_d`=1}, so the delay-slot instruction executes.
REQ-026 With `BRANCH_DELAY_SLOT_EN` undefined, a redirect edge SHALL load IF/ID with {0x00000000, `pc_f`, `pc_f`+8, `valid_d`=0}, squashing the fall-through instruction into a nop bubble.
REQ-027 Stall and reset behaviour SHALL be identical in both configurations.

Verification
REQ-028 Sequential fetch:
- Stimulus: reset for 2 cycles, then release; no stall, no redirect, for 3 cycles.
- Required: `pc_f` = 0x3000, 0x3004, 0x3008, 0x300C.
- Required: `ir_d` tracks `instr_f` one cycle late; `pc8_d`=`pc_d`+8.
REQ-029 Taken branch:
- Stimulus: at `pc_f`=0x3008, `br_true`=1, `br_target`=0x3020.
- Required: next `pc_f`=0x3020.
- Required with `BRANCH_DELAY_SLOT_EN`: `ir_d`=instr@0x3008, `valid_d`=1.
- Required without it: `ir_d`=0, `valid_d`=0.
REQ-030 Stall masks redirect:
- Stimulus: `stall`=1 and `jump`=1 with `jump_target`=0x3100 in the same cycle.
- Required: all outputs unchanged that cycle.
- Required: with `stall`=0 and `jump`=1 next cycle, `pc_f`=0x3100.
REQ-031 Priority and alignment:
- Stimulus: `jr`=1 with `jr_target`=0x3043, `br_true`=1 with `br_target`=0x3200, same cycle.
- Required: `pc_f`=0x3040.
REQ-032 Reset mid-redirect:
- Stimulus: `reset`=1 coincident with `br_true`=1, `br_target`=0x3400.
- Required: `pc_f`=0x3000, `valid_d`=0, `ir_d`=0.
- Required: first post-reset fetch at 0x3000.
REQ-033 Wrap-around:
- Stimulus: `jump_target`=0xFFFFFFFC, then sequential fetch.
- Required: `pc_f`=0xFFFFFFFC, then 0x00000000.
- Required: `pc8_d` for 0xFFFFFFFC = 0x00000004.
